cell_frame_reassembler: RTL and testbench

Parametrised cell-to-frame reassembler on the egress side of the switch fabric. It accepts fixed-length cells, CELL_BEATS beats each, from the output-queue scheduler with per-cell first/last/pad metadata, buffers them in an internal synchronous FWFT FIFO, and emits AXI4-Stream frames with correct tkeep/tlast. Compared with the previous egress post block it adds a store-and-forward mode, full tready compliance on every beat, malformed-sequence recovery with an abort marker, and status counters. The clock-domain crossing toward the MAC stays in a separate downstream AXIS FIFO.

---
 rtl/cell_frame_reassembler.sv | 229 ++++++++++++++++++++++
 tb/tb_cell_frame_reassembler.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_frame_reassembler.sv
// Cell-to-frame reassembler: buffers fabric cells in a first-word-fall-through
// FIFO and replays them as AXI4-Stream frames with tkeep, tlast and abort marking.
module cell_frame_reassembler #(
    parameter int DATA_W     = 64,
    parameter int KEEP_W     = DATA_W / 8,
    parameter int CELL_BEATS = 8,
    parameter int FIFO_DEPTH = 512,
    parameter int BP_THRESH  = 322,
    parameter bit STORE_FWD  = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_wr,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_first,
    input  logic                          in_last,
    input  logic [$clog2(CELL_BEATS)-1:0] in_pad,
    input  logic [$clog2(KEEP_W):0]       in_bytes,
    output logic                          in_bp,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [DATA_W-1:0]             m_axis_tdata,
    output logic [KEEP_W-1:0]             m_axis_tkeep,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    output logic [31:0]                   frame_cnt,
    output logic [15:0]                   err_cnt,
    output logic                          ovf
);

    localparam int IDX_W   = $clog2(CELL_BEATS);
    localparam int BYTES_W = $clog2(KEEP_W) + 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELL_BEATS - 1);

    typedef struct packed {
        logic               first;
        logic               last;
        logic [IDX_W-1:0]   pad;
        logic [BYTES_W-1:0] bytes;
        logic [DATA_W-1:0]  data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, FRAME, DISCARD, ABORT} state_t;

    entry_t             mem [FIFO_DEPTH];
    entry_t             head;
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count, frames_buf;
    logic [IDX_W-1:0]   wr_cnt, rd_idx;
    logic               full, empty, wr_ok, pop, buf_inc, buf_dec;

    state_t             state, state_next;
    logic               lat_last;
    logic [IDX_W-1:0]   lat_pad;
    logic [BYTES_W-1:0] lat_bytes;
    logic               cur_last, beat_end;
    logic [IDX_W-1:0]   cur_pad, nv_m1;
    logic [BYTES_W-1:0] cur_bytes;
    logic               can_load, frame_beat, emit, emit_last, load_abort, err_inc, frame_inc;
    logic [KEEP_W-1:0]  emit_keep, tail_keep;

    assign head     = mem[rd_ptr];
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign can_load = !m_axis_tvalid || m_axis_tready;
    assign wr_ok    = in_wr && (!full || pop);
    assign buf_inc  = wr_ok && in_last && (wr_cnt == LAST_IDX);
    assign buf_dec  = pop && cur_last && beat_end;

    // Cell metadata comes straight from the head on beat 0, then from the latch.
    assign cur_last  = (rd_idx == '0) ? head.last  : lat_last;
    assign cur_pad   = (rd_idx == '0) ? head.pad   : lat_pad;
    assign cur_bytes = (rd_idx == '0) ? head.bytes : lat_bytes;
    assign nv_m1     = LAST_IDX - cur_pad;
    assign beat_end  = (rd_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= {in_first, in_last, in_pad, in_bytes, in_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            frames_buf <= '0;
            wr_cnt     <= '0;
            in_bp      <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
                wr_cnt <= wr_cnt + IDX_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
            case ({buf_inc, buf_dec})
                2'b10:   frames_buf <= frames_buf + (AW+1)'(1);
                2'b01:   frames_buf <= frames_buf - (AW+1)'(1);
                default: ;
            endcase
            in_bp <= (count > (AW+1)'(BP_THRESH));
            if (in_wr && !wr_ok)
                ovf <= 1'b1;
        end
    end

    always_comb begin
        tail_keep = '1;
        if (cur_bytes != '0 && int'(cur_bytes) <= KEEP_W)
            for (int i = 0; i < KEEP_W; i++)
                tail_keep[i] = (i < int'(cur_bytes));
    end

    // A first cell arriving at a cell boundary while a frame is open forces an abort beat.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        frame_beat = 1'b0;
        emit       = 1'b0;
        emit_last  = 1'b0;
        emit_keep  = '1;
        load_abort = 1'b0;
        err_inc    = 1'b0;
        frame_inc  = 1'b0;
        case (state)
            IDLE: if (!empty && can_load) begin
                if (!head.first) begin
                    pop        = 1'b1;
                    err_inc    = 1'b1;
                    state_next = DISCARD;
                end else if (!STORE_FWD || frames_buf != '0) begin
                    pop        = 1'b1;
                    frame_beat = 1'b1;
                    state_next = FRAME;
                end
            end
            FRAME: if (!empty && can_load) begin
                if (rd_idx == '0 && head.first) begin
                    err_inc    = 1'b1;
                    state_next = ABORT;
                end else begin
                    pop        = 1'b1;
                    frame_beat = 1'b1;
                end
            end
            DISCARD: if (!empty && can_load) begin
                pop = 1'b1;
                if (beat_end)
                    state_next = IDLE;
            end
            ABORT: if (can_load) begin
                load_abort = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (frame_beat) begin
            if (!cur_last) begin
                emit = 1'b1;
            end else if (rd_idx <= nv_m1) begin
                emit = 1'b1;
                if (rd_idx == nv_m1) begin
                    emit_last = 1'b1;
                    emit_keep = tail_keep;
                    frame_inc = 1'b1;
                end
            end
            if (cur_last && beat_end)
                state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rd_idx        <= '0;
            lat_last      <= 1'b0;
            lat_pad       <= '0;
            lat_bytes     <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            frame_cnt     <= '0;
            err_cnt       <= '0;
        end else begin
            state <= state_next;
            if (pop) begin
                rd_idx <= rd_idx + IDX_W'(1);
                if (rd_idx == '0) begin
                    lat_last  <= head.last;
                    lat_pad   <= head.pad;
                    lat_bytes <= head.bytes;
                end
            end
            if (can_load) begin
                if (emit) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= head.data;
                    m_axis_tkeep  <= emit_keep;
                    m_axis_tlast  <= emit_last;
                    m_axis_tuser  <= 1'b0;
                end else if (load_abort) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= '0;
                    m_axis_tkeep  <= '0;
                    m_axis_tlast  <= 1'b1;
                    m_axis_tuser  <= 1'b1;
                end else begin
                    m_axis_tvalid <= 1'b0;
                end
            end
            if (frame_inc)
                frame_cnt <= frame_cnt + 32'd1;
            if (err_inc && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_cell_frame_reassembler.sv
// Bench for cell_frame_reassembler: a scoreboarded cut-through instance and a
// store-and-forward instance checked for start gating and latency.
`timescale 1ns/1ps
module tb_cell_frame_reassembler;

    localparam int CELL_BEATS = 8;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_wr, in_first, in_last;
    logic [63:0] in_data;
    logic [2:0]  in_pad;
    logic [3:0]  in_bytes;
    logic        in_bp, m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser, ovf;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic [31:0] frame_cnt;
    logic [15:0] err_cnt;

    logic        s_wr, s_first, s_last;
    logic [63:0] s_data;
    logic [2:0]  s_pad;
    logic [3:0]  s_bytes;
    logic        s_bp, s_tvalid, s_tready, s_tlast, s_tuser, s_ovf;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic [31:0] s_frame_cnt;
    logic [15:0] s_err_cnt;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    ready_mode = 1;
    int    sf_beats = 0;
    int    sf_last_at = 0;
    beat_t exp_q[$];
    beat_t held;
    bit    hold_pending = 1'b0;

    cell_frame_reassembler #(.STORE_FWD(1'b0)) dut (
        .clk(clk), .reset(reset), .in_wr(in_wr), .in_data(in_data), .in_first(in_first),
        .in_last(in_last), .in_pad(in_pad), .in_bytes(in_bytes), .in_bp(in_bp),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt), .ovf(ovf));

    cell_frame_reassembler #(.STORE_FWD(1'b1)) dut_sf (
        .clk(clk), .reset(reset), .in_wr(s_wr), .in_data(s_data), .in_first(s_first),
        .in_last(s_last), .in_pad(s_pad), .in_bytes(s_bytes), .in_bp(s_bp),
        .m_axis_tvalid(s_tvalid), .m_axis_tready(s_tready), .m_axis_tdata(s_tdata),
        .m_axis_tkeep(s_tkeep), .m_axis_tlast(s_tlast), .m_axis_tuser(s_tuser),
        .frame_cnt(s_frame_cnt), .err_cnt(s_err_cnt), .ovf(s_ovf));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Ready pattern: 0 = held low, 1 = held high, 2 = coin toss every cycle.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_axis_tready = 1'b0;
                2:       m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks stalled beats hold still.
    always @(negedge clk) begin
        beat_t got, e;
        got = '{data: m_axis_tdata, keep: m_axis_tkeep, last: m_axis_tlast, user: m_axis_tuser};
        if (reset || !m_axis_tvalid) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                checks++;
                if (got !== held) begin
                    failures++;
                    $display("[TB] FAIL stall_stable: got %h expected %h", got, held);
                end
            end
            if (m_axis_tready) begin
                hold_pending = 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_beat: got data=%h keep=%h last=%b user=%b expected none",
                             got.data, got.keep, got.last, got.user);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        failures++;
                        $display("[TB] FAIL beat: got data=%h keep=%h last=%b user=%b expected data=%h keep=%h last=%b user=%b",
                                 got.data, got.keep, got.last, got.user, e.data, e.keep, e.last, e.user);
                    end
                end
            end else begin
                hold_pending = 1'b1;
                held = got;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && s_tvalid && s_tready) begin
            sf_beats++;
            if (s_tlast)
                sf_last_at = sf_beats;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] keep_of(input int b);
        logic [7:0] ones;
        ones = 8'hFF;
        if (b == 0 || b > 8)
            return ones;
        return ones >> (8 - b);
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Writes one cell to the cut-through instance and queues the beats it must produce.
    task automatic apply_stimulus(input logic first, input logic last, input int pad,
                                  input int bytes, input logic [63:0] base, input bit expect_out);
        beat_t b;
        int nv;
        nv = CELL_BEATS - pad;
        if (expect_out) begin
            for (int i = 0; i < CELL_BEATS; i++) begin
                b.data = base + 64'(i);
                b.user = 1'b0;
                b.last = last && (i == nv - 1);
                b.keep = b.last ? keep_of(bytes) : 8'hFF;
                if (!last || i < nv)
                    exp_q.push_back(b);
            end
        end
        for (int i = 0; i < CELL_BEATS; i++) begin
            in_wr    = 1'b1;
            in_data  = base + 64'(i);
            in_first = first;
            in_last  = last;
            in_pad   = 3'(pad);
            in_bytes = 4'(bytes);
            @(posedge clk);
            #1;
        end
        in_wr = 1'b0;
    endtask

    task automatic sf_write_cell(input logic first, input logic last, output int c_last);
        c_last = 0;
        for (int i = 0; i < CELL_BEATS; i++) begin
            s_wr    = 1'b1;
            s_data  = 64'h9000 + 64'(i);
            s_first = first;
            s_last  = last;
            s_pad   = 3'd0;
            s_bytes = 4'd0;
            c_last  = cyc;
            @(posedge clk);
            #1;
        end
        s_wr = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: got %0d beats outstanding expected 0", exp_q.size());
        end
    endtask

    initial begin
        int c0, lat, t, viol;
        beat_t ab;
        in_wr = 0; in_data = '0; in_first = 0; in_last = 0; in_pad = '0; in_bytes = '0;
        s_wr = 0; s_data = '0; s_first = 0; s_last = 0; s_pad = '0; s_bytes = '0;
        s_tready = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_output("reset_tdata", m_axis_tdata, 64'd0);
        check_output("reset_tkeep", 64'(m_axis_tkeep), 64'd0);
        check_output("reset_tlast_tuser", 64'({m_axis_tlast, m_axis_tuser}), 64'd0);
        check_output("reset_in_bp", 64'(in_bp), 64'd0);
        check_output("reset_counters", {frame_cnt, err_cnt, 15'd0, ovf}, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] single-cell frame with cut-through latency");
        c0 = cyc;
        lat = -1;
        fork
            apply_stimulus(1'b1, 1'b1, 5, 3, 64'h1000, 1'b1);
            begin
                t = 0;
                while (lat < 0 && t < 10) begin
                    @(negedge clk);
                    if (m_axis_tvalid)
                        lat = cyc - c0;
                    t++;
                end
            end
        join
        check_output("cut_through_latency", 64'(lat), 64'd2);
        wait_drain();
        check_output("frame_cnt_1", 64'(frame_cnt), 64'd1);

        $display("[TB] three-cell frame under random ready");
        ready_mode = 2;
        apply_stimulus(1'b1, 1'b0, 0, 0, 64'h2000, 1'b1);
        apply_stimulus(1'b0, 1'b0, 0, 0, 64'h2100, 1'b1);
        apply_stimulus(1'b0, 1'b1, 0, 0, 64'h2200, 1'b1);
        wait_drain();
        ready_mode = 1;
        check_output("frame_cnt_2", 64'(frame_cnt), 64'd2);

        $display("[TB] orphan cell discarded, then good frame");
        apply_stimulus(1'b0, 1'b0, 0, 0, 64'h3000, 1'b0);
        apply_stimulus(1'b1, 1'b1, 0, 8, 64'h3100, 1'b1);
        wait_drain();
        check_output("err_cnt_discard", 64'(err_cnt), 64'd1);
        check_output("frame_cnt_3", 64'(frame_cnt), 64'd3);

        $display("[TB] open frame interrupted by new first cell");
        apply_stimulus(1'b1, 1'b0, 0, 0, 64'h4000, 1'b1);
        ab = '{data: 64'd0, keep: 8'h00, last: 1'b1, user: 1'b1};
        exp_q.push_back(ab);
        apply_stimulus(1'b1, 1'b1, 2, 5, 64'h4100, 1'b1);
        wait_drain();
        check_output("err_cnt_abort", 64'(err_cnt), 64'd2);
        check_output("frame_cnt_4", 64'(frame_cnt), 64'd4);

        $display("[TB] backpressure and overflow with ready low");
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 1; k <= 520; k++) begin
            in_wr    = 1'b1;
            in_data  = 64'(k);
            in_first = (k <= CELL_BEATS);
            in_last  = 1'b0;
            in_pad   = 3'd0;
            in_bytes = 4'd0;
            @(posedge clk);
            #1;
            if (k == 324) check_output("in_bp_before", 64'(in_bp), 64'd0);
            if (k == 325) check_output("in_bp_after", 64'(in_bp), 64'd1);
            if (k == 513) check_output("ovf_at_full", 64'(ovf), 64'd0);
            if (k == 514) check_output("ovf_set", 64'(ovf), 64'd1);
        end
        in_wr = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_output("ovf_sticky", 64'(ovf), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_output("ovf_cleared", 64'(ovf), 64'd0);
        check_output("in_bp_cleared", 64'(in_bp), 64'd0);
        check_output("tvalid_cleared", 64'(m_axis_tvalid), 64'd0);
        exp_q.delete();
        reset = 1'b0;
        ready_mode = 1;
        repeat (20) @(posedge clk);
        #1;
        check_output("frame_cnt_after_reset", 64'(frame_cnt), 64'd0);
        apply_stimulus(1'b1, 1'b1, 7, 2, 64'h5000, 1'b1);
        wait_drain();
        check_output("frame_cnt_post_reset", 64'(frame_cnt), 64'd1);

        $display("[TB] store-and-forward gating");
        sf_write_cell(1'b1, 1'b0, c0);
        sf_write_cell(1'b0, 1'b0, c0);
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_tvalid)
                viol++;
        end
        @(posedge clk);
        #1;
        check_output("sf_hold_tvalid", 64'(viol), 64'd0);
        sf_write_cell(1'b0, 1'b1, c0);
        lat = -1;
        t = 0;
        while (lat < 0 && t < 10) begin
            @(negedge clk);
            if (s_tvalid)
                lat = cyc - c0;
            t++;
        end
        check_output("sf_latency", 64'(lat), 64'd2);
        repeat (40) @(posedge clk);
        #1;
        check_output("sf_beats", 64'(sf_beats), 64'd24);
        check_output("sf_tlast_pos", 64'(sf_last_at), 64'd24);
        check_output("sf_frame_cnt", 64'(s_frame_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
